// File: rtl/axil_axis_tx_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_axis_tx_bridge_if : AXI-Lite slave channels plus AXI-Stream master.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface axil_axis_tx_bridge_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr;
  logic                        s_axil_awvalid;
  logic                        s_axil_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb;
  logic                        s_axil_wvalid;
  logic                        s_axil_wready;
  logic [1:0]                  s_axil_bresp;
  logic                        s_axil_bvalid;
  logic                        s_axil_bready;
  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr;
  logic                        s_axil_arvalid;
  logic                        s_axil_arready;
  logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata;
  logic [1:0]                  s_axil_rresp;
  logic                        s_axil_rvalid;
  logic                        s_axil_rready;
  logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata;
  logic                        m_axis_tlast;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;

  // Bridge side: AXI-Lite slave, stream master.
  modport slave (
    input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready, m_axis_tready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
           s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
           m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

  // Environment side: drives the register bus, sinks the stream.
  modport master (
    output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready, m_axis_tready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
           s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
           m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/axil_axis_tx_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_axis_tx_bridge : AXI-Lite register writes pushed to AXI-Stream FIFO.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axil_axis_tx_bridge #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH     = 16
) (
  input  wire logic            aclk,
  input  wire logic            aresetn,
  axil_axis_tx_bridge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = AXI_DATA_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // FIFO storage and pointers
  logic [DW:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  // Write channel state
  wstate_t       wstate_q, wstate_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic [1:0]    waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [15:0]   drop_q, drop_d;

  // Read channel state
  rstate_t       rstate_q, rstate_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rd_mux;

  logic          unused_bits;
  assign unused_bits = &{1'b0, bus.s_axil_wstrb,
                         bus.s_axil_awaddr[AXI_ADDR_WIDTH-1:4], bus.s_axil_awaddr[1:0],
                         bus.s_axil_araddr[AXI_ADDR_WIDTH-1:4], bus.s_axil_araddr[1:0]};

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == PW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.m_axis_tready;

  assign bus.m_axis_tvalid = !fifo_empty;
  assign bus.m_axis_tdata  = mem_q[rd_ptr_q[AW-1:0]][DW-1:0];
  assign bus.m_axis_tlast  = mem_q[rd_ptr_q[AW-1:0]][DW];

  assign bus.s_axil_awready = awready_q;
  assign bus.s_axil_wready  = wready_q;
  assign bus.s_axil_bvalid  = bvalid_q;
  assign bus.s_axil_bresp   = bresp_q;
  assign bus.s_axil_arready = arready_q;
  assign bus.s_axil_rvalid  = rvalid_q;
  assign bus.s_axil_rdata   = rdata_q;
  assign bus.s_axil_rresp   = rresp_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  // Write FSM: AW and W are captured independently; the side effect fires
  // on the edge that moves to W_RESP, using the registered full flag.
  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    drop_d    = drop_q;
    push      = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        awready_d = !aw_held_q;
        wready_d  = !w_held_q;
        if (bus.s_axil_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = bus.s_axil_awaddr[3:2];
          awready_d = 1'b0;
        end
        if (bus.s_axil_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = bus.s_axil_wdata;
          wready_d = 1'b0;
        end
        if (aw_held_q && w_held_q) begin
          wstate_d  = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_OKAY;
          unique case (waddr_q)
            2'b00, 2'b01: begin
              if (!fifo_full) begin
                push = 1'b1;
              end else begin
                bresp_d = RESP_SLVERR;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
              end
            end
            2'b10:   bresp_d = RESP_SLVERR;
            default: drop_d  = '0;
          endcase
        end
      end
      W_RESP: begin
        if (bus.s_axil_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    unique case (bus.s_axil_araddr[3:2])
      2'b10:   rd_mux = DW'({16'h0, 8'(level), 6'h0, fifo_full, fifo_empty});
      2'b11:   rd_mux = DW'({16'h0, drop_q});
      default: rd_mux = '0;
    endcase
  end

  // Read FSM: single-cycle latency, status sampled at the AR handshake.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (bus.s_axil_arvalid && arready_q) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_mux;
          rresp_d   = RESP_OKAY;
        end
      end
      R_DATA: begin
        if (bus.s_axil_rready) begin
          rstate_d  = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      drop_q    <= '0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      drop_q    <= drop_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Storage has no reset; emptiness is defined purely by the pointers.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {waddr_q[0], wdata_q};
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_axis_tx_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axil_axis_tx_bridge : directed self-checking bench for the bridge.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axil_axis_tx_bridge;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic        rand_mode = 1'b0;
  logic        tready_fixed = 1'b0;
  logic        rnd = 1'b0;
  logic [32:0] beats[$];
  logic [32:0] prev_beat = '0;
  logic        prev_stall = 1'b0;

  logic [31:0] rd;
  logic [1:0]  rr;
  logic [1:0]  br;
  int          bad;
  int          n;

  always #5 aclk = ~aclk;

  axil_axis_tx_bridge_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) ax ();

  axil_axis_tx_bridge #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .FIFO_DEPTH(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(ax)
  );

  always @(negedge aclk) rnd <= 1'($urandom_range(0, 1));
  assign ax.m_axis_tready = rand_mode ? rnd : tready_fixed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: sampled mid-low-phase, after all input changes settle.
  always begin
    @(negedge aclk);
    #1;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("tstall_hold", {31'h0, ax.m_axis_tvalid, ax.m_axis_tlast, ax.m_axis_tdata},
            {31'h0, 1'b1, prev_beat});
      if (ax.m_axis_tvalid && ax.m_axis_tready)
        beats.push_back({ax.m_axis_tlast, ax.m_axis_tdata});
      prev_stall = ax.m_axis_tvalid && !ax.m_axis_tready;
      prev_beat  = {ax.m_axis_tlast, ax.m_axis_tdata};
    end
  end

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    int k = 0;
    int nb = 0;
    int stall_bad = 0;
    logic [1:0] b0;
    while (!(aw_done && w_done) && k < 60) begin
      @(negedge aclk);
      if (aw_done) ax.s_axil_awvalid = 1'b0;
      else if (k >= aw_dly) begin ax.s_axil_awaddr = addr; ax.s_axil_awvalid = 1'b1; end
      if (w_done) ax.s_axil_wvalid = 1'b0;
      else if (k >= w_dly) begin ax.s_axil_wdata = data; ax.s_axil_wvalid = 1'b1; end
      #1;
      if (ax.s_axil_awvalid && ax.s_axil_awready) aw_done = 1;
      if (ax.s_axil_wvalid && ax.s_axil_wready) w_done = 1;
      k++;
    end
    @(negedge aclk);
    ax.s_axil_awvalid = 1'b0;
    ax.s_axil_wvalid  = 1'b0;
    chk("aw_w_accept", {62'h0, aw_done, w_done}, 64'h3);
    ax.s_axil_bready = 1'b0;
    while (!ax.s_axil_bvalid && nb < 20) begin @(negedge aclk); nb++; end
    chk("bvalid_seen", {63'h0, ax.s_axil_bvalid}, 64'h1);
    b0 = ax.s_axil_bresp;
    for (int j = 0; j < b_dly; j++) begin
      ax.s_axil_awaddr  = 32'h8;
      ax.s_axil_awvalid = 1'b1;
      ax.s_axil_wdata   = 32'h0BAD_0BAD;
      ax.s_axil_wvalid  = 1'b1;
      @(negedge aclk);
      if (!(ax.s_axil_bvalid === 1'b1 && ax.s_axil_bresp === b0 &&
            ax.s_axil_awready === 1'b0 && ax.s_axil_wready === 1'b0)) stall_bad++;
    end
    if (b_dly > 0) chk("b_stall_stable", 64'(stall_bad), 64'h0);
    ax.s_axil_awvalid = 1'b0;
    ax.s_axil_wvalid  = 1'b0;
    resp = ax.s_axil_bresp;
    ax.s_axil_bready = 1'b1;
    @(negedge aclk);
    ax.s_axil_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
    int na = 0;
    @(negedge aclk);
    ax.s_axil_araddr  = addr;
    ax.s_axil_arvalid = 1'b1;
    ax.s_axil_rready  = 1'b0;
    while (!ax.s_axil_arready && na < 20) begin @(negedge aclk); na++; end
    chk("arready_seen", {63'h0, ax.s_axil_arready}, 64'h1);
    @(negedge aclk);
    ax.s_axil_arvalid = 1'b0;
    chk("read_latency", {63'h0, ax.s_axil_rvalid}, 64'h1);
    data = ax.s_axil_rdata;
    resp = ax.s_axil_rresp;
    ax.s_axil_rready = 1'b1;
    @(negedge aclk);
    ax.s_axil_rready = 1'b0;
  endtask

  task automatic wait_beats(input int cnt);
    int nw = 0;
    while (beats.size() < cnt && nw < 300) begin @(negedge aclk); nw++; end
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    ax.s_axil_awaddr = '0; ax.s_axil_awvalid = 1'b0;
    ax.s_axil_wdata  = '0; ax.s_axil_wstrb = 4'hF; ax.s_axil_wvalid = 1'b0;
    ax.s_axil_bready = 1'b0;
    ax.s_axil_araddr = '0; ax.s_axil_arvalid = 1'b0; ax.s_axil_rready = 1'b0;

    // Reset and first edge after release
    repeat (3) @(negedge aclk);
    chk("in_reset", {58'h0, ax.s_axil_awready, ax.s_axil_wready, ax.s_axil_arready,
                     ax.s_axil_bvalid, ax.s_axil_rvalid, ax.m_axis_tvalid}, 64'h0);
    aresetn = 1'b1;
    #1;
    chk("ready_pre_edge", {61'h0, ax.s_axil_awready, ax.s_axil_wready, ax.s_axil_arready}, 64'h0);
    @(negedge aclk);
    chk("ready_post_edge", {58'h0, ax.s_axil_awready, ax.s_axil_wready, ax.s_axil_arready,
                            ax.s_axil_bvalid, ax.s_axil_rvalid, ax.m_axis_tvalid}, 64'h38);
    axil_read(32'h8, rd, rr);
    chk("status_idle", {30'h0, rr, rd}, 64'h0000_0001);

    // Push and drain with tready high
    tready_fixed = 1'b1;
    beats.delete();
    axil_write(32'h0, 32'hA5A5_0001, 0, 0, 0, br);
    chk("push0_bresp", 64'(br), 64'h0);
    axil_write(32'h4, 32'hA5A5_0002, 0, 0, 0, br);
    chk("push1_bresp", 64'(br), 64'h0);
    wait_beats(2);
    chk("drain_count", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      chk("beat0", 64'(beats[0]), {31'h0, 1'b0, 32'hA5A5_0001});
      chk("beat1", 64'(beats[1]), {31'h0, 1'b1, 32'hA5A5_0002});
    end

    // Fill to full, then overflow
    tready_fixed = 1'b0;
    beats.delete();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      axil_write(32'h0, 32'(32'h1000_0000 + i), 0, 0, 0, br);
      if (br !== 2'b00) bad++;
    end
    chk("fill_okay", 64'(bad), 64'h0);
    axil_read(32'h8, rd, rr);
    chk("status_full", 64'(rd), 64'h0000_1002);
    axil_write(32'h0, 32'hFFFF_FFFF, 0, 0, 0, br);
    chk("overflow_bresp", 64'(br), 64'h2);
    axil_read(32'hC, rd, rr);
    chk("drop_one", 64'(rd), 64'h1);
    tready_fixed = 1'b1;
    wait_beats(16);
    chk("fill_count", 64'(beats.size()), 64'd16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= beats.size() || beats[i] !== {1'b0, 32'(32'h1000_0000 + i)}) bad++;
    chk("fill_order", 64'(bad), 64'h0);
    chk("tvalid_after_drain", {63'h0, ax.m_axis_tvalid}, 64'h0);

    // Skewed AW/W with B backpressure
    beats.delete();
    axil_write(32'h0, 32'hDEAD_0001, 3, 0, 5, br);
    chk("skew_w_first", 64'(br), 64'h0);
    axil_write(32'h4, 32'hBEEF_0002, 0, 2, 5, br);
    chk("skew_aw_first", 64'(br), 64'h0);
    wait_beats(2);
    chk("skew_count", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      chk("skew_beat0", 64'(beats[0]), {31'h0, 1'b0, 32'hDEAD_0001});
      chk("skew_beat1", 64'(beats[1]), {31'h0, 1'b1, 32'hBEEF_0002});
    end

    // Random backpressure interleaved with status polling
    beats.delete();
    rand_mode = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      axil_write(32'h0, 32'(32'h5000_0000 + i), 0, 0, 0, br);
      axil_read(32'h8, rd, rr);
      if (rd[15:8] > 8'd16 || br !== 2'b00) bad++;
    end
    chk("bp_level_ok", 64'(bad), 64'h0);
    rand_mode = 1'b0;
    tready_fixed = 1'b1;
    wait_beats(12);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (i >= beats.size() || beats[i] !== {1'b0, 32'(32'h5000_0000 + i)}) bad++;
    chk("bp_order", 64'(bad), 64'h0);
    chk("bp_count", 64'(beats.size()), 64'd12);

    axil_write(32'hC, 32'h0, 0, 0, 0, br);
    chk("drop_clr_bresp", 64'(br), 64'h0);
    axil_read(32'hC, rd, rr);
    chk("drop_cleared", 64'(rd), 64'h0);

    tready_fixed = 1'b0;
    beats.delete();
    for (int i = 0; i < 3; i++) axil_write(32'h0, 32'(32'h7000_0000 + i), 0, 0, 0, br);
    axil_read(32'h8, rd, rr);
    chk("status_three", 64'(rd), 64'h0000_0300);
    axil_write(32'h8, 32'hFFFF_FFFF, 0, 0, 0, br);
    chk("status_wr_slverr", 64'(br), 64'h2);
    axil_read(32'h8, rd, rr);
    chk("status_unchanged", 64'(rd), 64'h0000_0300);
    axil_read(32'h0, rd, rr);
    chk("read_txdata_zero", {30'h0, rr, rd}, 64'h0);

    // Reset while a response is pending and the FIFO holds five words
    for (int i = 3; i < 5; i++) axil_write(32'h0, 32'(32'h7000_0000 + i), 0, 0, 0, br);
    @(negedge aclk);
    ax.s_axil_awaddr = 32'hC; ax.s_axil_awvalid = 1'b1;
    ax.s_axil_wdata  = 32'h0; ax.s_axil_wvalid  = 1'b1;
    ax.s_axil_bready = 1'b0;
    @(negedge aclk);
    ax.s_axil_awvalid = 1'b0; ax.s_axil_wvalid = 1'b0;
    n = 0;
    while (!ax.s_axil_bvalid && n < 20) begin @(negedge aclk); n++; end
    chk("pre_rst_state", {62'h0, ax.s_axil_bvalid, ax.m_axis_tvalid}, 64'h3);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_async", {58'h0, ax.s_axil_bvalid, ax.m_axis_tvalid, ax.s_axil_awready,
                      ax.s_axil_wready, ax.s_axil_arready, ax.s_axil_rvalid}, 64'h0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    beats.delete();
    tready_fixed = 1'b1;
    repeat (6) @(negedge aclk);
    chk("no_stale_beat", 64'(beats.size()), 64'd0);
    chk("tvalid_post_rst", {63'h0, ax.m_axis_tvalid}, 64'h0);
    axil_read(32'h8, rd, rr);
    chk("status_post_rst", 64'(rd), 64'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/axil_axis_tx_bridge.md
Name: axil_axis_tx_bridge

Overview:
AXI-Lite slave that consumes the s_axil register-access channel set and turns CPU register writes into an AXI-Stream master output through an internal FIFO. Software pushes 32-bit words, with or without TLAST. Software polls FIFO status and a drop counter. It is the register-side terminus of the AXI-Lite-to-stream converter, and it feeds downstream stream logic.

Parameters:
- AXI_DATA_WIDTH, 32: AXI-Lite and stream data width. Only 32 is supported.
- AXI_ADDR_WIDTH, 32: AXI-Lite address width. Only bits [3:2] are decoded; all other bits are ignored.
- FIFO_DEPTH, 16: stream FIFO entries. Must be a power of two, 2..128.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  AXI_DATA_WIDTH  write data.
- s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte strobes. Ignored: the full word is always pushed.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  AXI_DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- m_axis_tdata  out  AXI_DATA_WIDTH  stream data.
- m_axis_tlast  out  1  stream last.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.

Behaviour:

Register map (offset = addr[3:2]):
- 0x0 TX_DATA, write-only: push {wdata, tlast=0}.
- 0x4 TX_LAST, write-only: push {wdata, tlast=1}.
- 0x8 STATUS, read-only:
  - [0] fifo_empty
  - [1] fifo_full
  - [15:8] fifo level (0..FIFO_DEPTH)
  - all other bits 0
- 0xC DROP: read returns the 16-bit drop count in [15:0], upper bits 0. Any write clears it to 0 and returns OKAY.
- Reads of 0x0 or 0x4 return 0 with OKAY.

Reset (aresetn low, asynchronous):
- All ready/valid outputs are 0; bresp, rresp and rdata are 0.
- FIFO is emptied and the drop count is cleared.
- Any in-flight transaction is discarded and the write and read FSMs return to their idle states.
- awready, wready and arready are registered. They are first 1 on the first rising edge after aresetn is released.

Write FSM:
- W_IDLE: awready=1 until an address is captured; wready=1 until data is captured. AW and W may arrive in the same cycle or in either order; each is held once captured.
- When both are held, go to W_RESP on the next edge. On that same edge, perform the side effect and register bresp; bvalid=1 from that edge.
- Push side effect for 0x0/0x4:
  - If the FIFO is not full: push the word.
  - If the FIFO is full: drop the word, return SLVERR, and increment DROP. DROP saturates at 0xFFFF.
  - The full decision uses the registered full flag. A simultaneous stream pop does not rescue a push in that cycle.
- Writes to STATUS return SLVERR and have no effect.
- W_RESP: hold bvalid and bresp until bready. On the handshake, return to W_IDLE with awready and wready at 1 on the next cycle.
- Throughput: at most one write per 3 cycles.

Read FSM:
- R_IDLE: arready=1. On the AR handshake, register rdata and rresp on the next edge and go to R_DATA with rvalid=1. Read latency is 1 cycle.
- R_DATA: hold rdata, rresp and rvalid until rready, then return to R_IDLE.
- STATUS is sampled at the AR handshake edge.
- The read and write FSMs are fully independent. A DROP clear and a DROP read on the same edge return the pre-clear value.

FIFO and stream:
- First-word fall-through.
- m_axis_tvalid = !empty. tvalid first rises the cycle after the push edge.
- tdata and tlast must be stable while tvalid=1 and tready=0.
- A pop occurs on tvalid&&tready.
- A simultaneous push and pop is allowed when not full; the level is unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- full = (level == FIFO_DEPTH).

Test Plan:
- Post-reset idle: release aresetn → next edge awready=wready=arready=1, all valids 0. Read 0x8 → rdata=0x00000001, rresp=00, one cycle after the AR handshake.
- Push and drain, tready=1: write 0x0=0xA5A5_0001 then 0x4=0xA5A5_0002 → stream beats 0xA5A50001 (tlast=0) then 0xA5A50002 (tlast=1). Both bresp=00.
- Fill and overflow, FIFO_DEPTH=16, tready=0: 16 writes to 0x0 → all OKAY, STATUS=0x00001002. A 17th write → bresp=10 and DROP reads 1. Then tready=1 → exactly 16 beats in order, tvalid drops afterward.
- Skewed AW/W: W valid 3 cycles before AW, then AW before W, with bready held low 5 cycles → data captured correctly, bvalid held stable, no second transaction accepted until the B handshake.
- Backpressure and concurrency: random tready while reads of 0x8 run continuously → level never exceeds 16, tdata stable under stall. Write 0xC → DROP reads 0. Writing 0x8 → SLVERR, and the FIFO is unchanged.
- Mid-operation reset: assert aresetn low while bvalid=1 and the FIFO holds 5 words → outputs go to 0 immediately (asynchronously), FIFO empty after release, no stale beat on m_axis.
